// File: rtl/strela_cg_pkg.sv
// rtl/strela_cg_pkg.sv - shared types and constants for the STRELA clock-gate controller
package strela_cg_pkg;

  typedef enum logic [1:0] {CG_RUN, CG_DRAIN, CG_OFF, CG_WAKE} cg_state_e;

  localparam int DEFAULT_IDLE = 16;

endpackage

// File: rtl/strela_clock_gate.sv
// rtl/strela_clock_gate.sv - behavioural latch-based clock gate, replaced by a library ICG in synthesis
module strela_clock_gate (
  input  logic clk_i,
  input  logic test_en_i,
  input  logic en_i,
  output logic clk_o
);

  logic en_lat;

  // Transparent only while clk_i is low, so the enable cannot change inside a high phase.
  always_latch begin
    if (!clk_i) en_lat = en_i | test_en_i;
  end

  assign clk_o = clk_i & en_lat;

endmodule

// File: rtl/strela_clock_gate_ctrl.sv
// rtl/strela_clock_gate_ctrl.sv - multi-channel idle-driven clock gating controller
// Optional gated-cycle statistics counters are built when STRELA_CG_STATS_EN is defined.
module strela_clock_gate_ctrl
  import strela_cg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 8,
  parameter int STAT_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     test_en_i,
  input  logic [CNT_W-1:0]         idle_cycles_i,
  input  logic [NUM_CH-1:0]        force_on_i,
  input  logic [NUM_CH-1:0]        busy_i,
  input  logic [NUM_CH-1:0]        wake_req_i,
  output logic [NUM_CH-1:0]        wake_ack_o,
  output logic [NUM_CH-1:0]        gated_o,
  output logic [NUM_CH-1:0]        clk_o,
  output logic [NUM_CH*STAT_W-1:0] stat_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    cg_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             active;
    logic             en;

    assign active = busy_i[g] | force_on_i[g] | wake_req_i[g];

    // Activity always wins over an expiring counter; a zero threshold never leaves RUN.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q <= CG_RUN;
        cnt_q   <= idle_cycles_i;
      end else begin
        case (state_q)
          CG_RUN: begin
            if (active) begin
              cnt_q <= idle_cycles_i;
            end else begin
              if (cnt_q == CNT_W'(1) && idle_cycles_i != '0) state_q <= CG_DRAIN;
              if (cnt_q != '0) cnt_q <= cnt_q - CNT_W'(1);
            end
          end
          CG_DRAIN: begin
            if (active) begin
              state_q <= CG_RUN;
              cnt_q   <= idle_cycles_i;
            end else begin
              state_q <= CG_OFF;
            end
          end
          CG_OFF: begin
            if (active) state_q <= CG_WAKE;
          end
          CG_WAKE: begin
            state_q <= CG_RUN;
            cnt_q   <= idle_cycles_i;
          end
          default: begin
            state_q <= CG_RUN;
            cnt_q   <= idle_cycles_i;
          end
        endcase
      end
    end

    // Reset forces the clock on so gated domains see reset even when caught in OFF.
    assign en            = (state_q != CG_OFF) | rst_i;
    assign wake_ack_o[g] = (state_q == CG_RUN);
    assign gated_o[g]    = (state_q == CG_OFF);

    strela_clock_gate u_gate (
      .clk_i     (clk_i),
      .test_en_i (test_en_i),
      .en_i      (en),
      .clk_o     (clk_o[g])
    );

`ifdef STRELA_CG_STATS_EN
    logic [STAT_W-1:0] stat_q;

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        stat_q <= '0;
      end else if (state_q == CG_OFF && stat_q != '1) begin
        stat_q <= stat_q + STAT_W'(1);
      end
    end

    assign stat_o[g*STAT_W +: STAT_W] = stat_q;
`else
    assign stat_o[g*STAT_W +: STAT_W] = '0;
`endif
  end

endmodule
